// File: rtl/ysyx_25040129_regfile_sb_pkg.sv
// Shared constants for the scoreboarded integer register file.
package ysyx_25040129_regfile_sb_pkg;

  // Clear/run state encoding (kept as plain constants for legacy tooling).
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Architectural register counts for the two supported base ISAs.
  localparam int unsigned NREGS_RV32E = 16;
  localparam int unsigned NREGS_RV32I = 32;

  // x0 is hardwired to zero and never stored.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/ysyx_25040129_rf_rdport.sv
// One combinational read port: register mux, x0 forcing and optional
// same-cycle write forwarding. Outputs are forced to zero until the
// clear sequence has finished.
module ysyx_25040129_rf_rdport
  import ysyx_25040129_regfile_sb_pkg::*;
#(
  parameter int NREGS  = 16,
  parameter int XLEN   = 32,
  parameter int AW     = 4,
  parameter int BYPASS = 1
) (
  input  logic                    run,
  input  logic [AW-1:0]           addr,
  input  logic [NREGS*XLEN-1:0]   regs_flat,
  input  logic [NREGS-1:0]        busy,
  input  logic                    wen,
  input  logic [AW-1:0]           waddr,
  input  logic [XLEN-1:0]         wdata,
  output logic [XLEN-1:0]         data,
  output logic                    busy_out
);

  // Select forwarded write data, stored data, or zero.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
    data     = '0;
    busy_out = 1'b0;
    if (run && addr != AW'(ZERO_REG)) begin
      if (BYPASS != 0 && wen && waddr == addr) begin
        // The in-flight write satisfies the consumer, so it is not busy.
        data = wdata;
      end else begin
        data     = regs_flat[int'(addr)*XLEN +: XLEN];
        busy_out = busy[addr];
      end
    end
  end

endmodule

// File: rtl/ysyx_25040129_regfile_sb.sv
// Integer register file with per-register busy bits, optional write-to-read
// forwarding and a post-reset clear sequencer that zeroes x1..x(NREGS-1).
module ysyx_25040129_regfile_sb
  import ysyx_25040129_regfile_sb_pkg::*;
#(
  parameter int NREGS  = NREGS_RV32E,
  parameter int XLEN   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wen,
  input  logic [AW-1:0]        waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  output logic                 ready
);

  logic [0:0]            state;
  logic [AW:0]           clr_idx;   // one spare bit so it cannot wrap before the last compare
  logic [NREGS-1:0]      busy;
  logic [NREGS*XLEN-1:0] regs_flat;
  logic                  run;
  logic                  clr_last;

  assign run      = (state == ST_RUN);
  assign clr_last = (clr_idx == (AW+1)'(NREGS-1));

  // Clear sequencer: walk x1..x(NREGS-1), then hand over to RUN.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state   <= ST_CLEAR;
      clr_idx <= (AW+1)'(1);
      ready   <= 1'b0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + (AW+1)'(1);
      if (clr_last) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end
    end
  end

  // Storage x1..x(NREGS-1); slot 0 of the flat bus is a constant zero.
  assign regs_flat[0 +: XLEN] = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_reg
    logic [XLEN-1:0] q;

    // Zero during the clear walk, otherwise take writeback data.
    always_ff @(posedge clk) begin
      // NOTE: data flops have no reset term; the clear sequencer zeroes them instead.
      if (rst) begin
        if (state == ST_CLEAR) begin
          if (clr_idx == (AW+1)'(g)) q <= '0;
        end else if (wen && waddr == AW'(g)) begin
          q <= wdata;
        end
      end
    end

    assign regs_flat[g*XLEN +: XLEN] = q;
  end

  // Scoreboard: writeback retires a producer, issue marks a new one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else if (run) begin
      if (wen && waddr != AW'(ZERO_REG))      busy[waddr]   <= 1'b0;
      // NOTE: the later non-blocking assignment wins, so a same-edge issue keeps the register busy.
      if (sb_set && sb_addr != AW'(ZERO_REG)) busy[sb_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    ysyx_25040129_rf_rdport #(
      .NREGS  (NREGS),
      .XLEN   (XLEN),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rdport (
      .run       (run),
      .addr      (rd_addr[p*AW +: AW]),
      .regs_flat (regs_flat),
      .busy      (busy),
      .wen       (wen),
      .waddr     (waddr),
      .wdata     (wdata),
      .data      (rd_data[p*XLEN +: XLEN]),
      .busy_out  (rd_busy[p])
    );
  end

`ifdef DEBUG
  logic [XLEN-1:0] dbg_regs [NREGS];

  // Register-dump hook for the simulator; x0 comes from the zero slot.
  always_comb begin
    for (int i = 0; i < NREGS; i++) dbg_regs[i] = regs_flat[i*XLEN +: XLEN];
  end
`endif

endmodule

// File: tb/tb_ysyx_25040129_regfile_sb.sv
// Directed bench: a 16-entry bypassing file, a 16-entry non-bypassing file
// and a 32-entry file share one stimulus stream.
module tb_ysyx_25040129_regfile_sb;

  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int AW16 = 4;
  localparam int AW32 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NRD*AW16-1:0]  rd_addr;
  logic [NRD*AW32-1:0]  rd_addr32;
  logic                 wen;
  logic [AW16-1:0]      waddr;
  logic [XLEN-1:0]      wdata;
  logic                 sb_set;
  logic [AW16-1:0]      sb_addr;
  logic [AW32-1:0]      waddr32;
  logic [AW32-1:0]      sb_addr32;

  assign waddr32   = {1'b0, waddr};
  assign sb_addr32 = {1'b0, sb_addr};

  logic [NRD*XLEN-1:0]  rd_data, rd_data_nb, rd_data32;
  logic [NRD-1:0]       rd_busy, rd_busy_nb, rd_busy32;
  logic                 ready, ready_nb, ready32;

  int n_checks = 0;
  int n_pass   = 0;

  ysyx_25040129_regfile_sb #(.NREGS(16), .XLEN(XLEN), .NRD(NRD), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .sb_set(sb_set), .sb_addr(sb_addr),
    .ready(ready)
  );

  ysyx_25040129_regfile_sb #(.NREGS(16), .XLEN(XLEN), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wen(wen), .waddr(waddr), .wdata(wdata), .sb_set(sb_set), .sb_addr(sb_addr),
    .ready(ready_nb)
  );

  ysyx_25040129_regfile_sb #(.NREGS(32), .XLEN(XLEN), .NRD(NRD), .BYPASS(1)) dut32 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr32), .rd_data(rd_data32), .rd_busy(rd_busy32),
    .wen(wen), .waddr(waddr32), .wdata(wdata), .sb_set(sb_set), .sb_addr(sb_addr32),
    .ready(ready32)
  );

  // Advance past one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wen = 1'b0; waddr = '0; wdata = '0; sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic test_reset();
    logic exp16, exp32;
    rst = 1'b0; idle_inputs(); rd_addr = {4'd3, 4'd5}; rd_addr32 = {5'd20, 5'd3};
    repeat (3) tick();
    n_checks++;
    if (ready !== 1'b0 || ready32 !== 1'b0 || ready_nb !== 1'b0)
      $display("FAIL reset_ready: got %b/%b/%b want 0/0/0", ready, ready_nb, ready32);
    else n_pass++;
    rst = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      tick();
      exp16 = (e >= 15);
      exp32 = (e >= 31);
      n_checks++;
      if (ready !== exp16 || ready_nb !== exp16)
        $display("FAIL clear16_ready edge %0d: got %b/%b want %b", e, ready, ready_nb, exp16);
      else n_pass++;
      n_checks++;
      if (ready32 !== exp32)
        $display("FAIL clear32_ready edge %0d: got %b want %b", e, ready32, exp32);
      else n_pass++;
      if (e < 15) begin
        n_checks++;
        if (rd_data !== '0 || rd_busy !== '0)
          $display("FAIL clear16_reads edge %0d: got %h busy %b want 0", e, rd_data, rd_busy);
        else n_pass++;
      end
    end
    for (int a = 0; a < 16; a++) begin
      rd_addr = {4'(15 - a), 4'(a)};
      #1;
      n_checks++;
      if (rd_data !== '0 || rd_busy !== '0)
        $display("FAIL zero16 x%0d: got %h busy %b want 0", a, rd_data, rd_busy);
      else n_pass++;
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr32 = {5'(31 - a), 5'(a)};
      #1;
      n_checks++;
      if (rd_data32 !== '0 || rd_busy32 !== '0)
        $display("FAIL zero32 x%0d: got %h busy %b want 0", a, rd_data32, rd_busy32);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_write_read();
    wen = 1'b1; waddr = 4'd5; wdata = 32'hDEADBEEF;
    tick();
    waddr = 4'd0; wdata = 32'h0000_1234;
    tick();
    idle_inputs();
    rd_addr = {4'd0, 4'd5};
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF)
      $display("FAIL wr_x5: got %h want deadbeef", rd_data[31:0]);
    else n_pass++;
    n_checks++;
    if (rd_data[63:32] !== 32'h0 || rd_busy[1] !== 1'b0)
      $display("FAIL wr_x0: got %h busy %b want 0", rd_data[63:32], rd_busy[1]);
    else n_pass++;
  endtask

  task automatic test_bypass();
    sb_set = 1'b1; sb_addr = 4'd7;
    tick();
    idle_inputs();
    rd_addr = {4'd7, 4'd7};
    wen = 1'b1; waddr = 4'd7; wdata = 32'hA5A5A5A5;
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hA5A5A5A5 || rd_busy[0] !== 1'b0)
      $display("FAIL bypass_on: got %h busy %b want a5a5a5a5 busy 0", rd_data[31:0], rd_busy[0]);
    else n_pass++;
    n_checks++;
    if (rd_data_nb[31:0] !== 32'h0 || rd_busy_nb[0] !== 1'b1)
      $display("FAIL bypass_off: got %h busy %b want 0 busy 1", rd_data_nb[31:0], rd_busy_nb[0]);
    else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_data_nb[63:32] !== 32'hA5A5A5A5 || rd_busy_nb[1] !== 1'b0)
      $display("FAIL bypass_off_after: got %h busy %b want a5a5a5a5 busy 0", rd_data_nb[63:32], rd_busy_nb[1]);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    rd_addr = {4'd3, 4'd3};
    sb_set = 1'b1; sb_addr = 4'd3;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_busy !== 2'b11)
      $display("FAIL sb_set_x3: got %b want 11", rd_busy);
    else n_pass++;
    sb_set = 1'b1; sb_addr = 4'd0;
    tick();
    idle_inputs();
    sb_set = 1'b1; sb_addr = 4'd3; wen = 1'b1; waddr = 4'd3; wdata = 32'h11;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h11 || rd_data[63:32] !== 32'h11)
      $display("FAIL sb_same_edge: got %h/%h busy %b want 11 busy 1", rd_data[31:0], rd_data[63:32], rd_busy[0]);
    else n_pass++;
    wen = 1'b1; waddr = 4'd3; wdata = 32'h22;
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h22)
      $display("FAIL sb_retire: got %h busy %b want 22 busy 00", rd_data[31:0], rd_busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    wen = 1'b1; waddr = 4'd9; wdata = 32'h55; sb_set = 1'b1; sb_addr = 4'd9;
    tick();
    idle_inputs();
    rd_addr = {4'd9, 4'd9};
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h55 || rd_busy[0] !== 1'b1)
      $display("FAIL midrun_setup: got %h busy %b want 55 busy 1", rd_data[31:0], rd_busy[0]);
    else n_pass++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++;
    if (ready !== 1'b0 || rd_data !== '0 || rd_busy !== '0)
      $display("FAIL midrun_reset: got ready %b data %h busy %b want 0", ready, rd_data, rd_busy);
    else n_pass++;
    for (int e = 1; e <= 15; e++) begin
      tick();
      n_checks++;
      if (ready !== (e == 15))
        $display("FAIL midrun_ready edge %0d: got %b want %b", e, ready, (e == 15));
      else n_pass++;
    end
    n_checks++;
    if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0)
      $display("FAIL midrun_x9: got %h busy %b want 0 busy 0", rd_data[31:0], rd_busy[0]);
    else n_pass++;
  endtask

  task automatic test_clear_traffic();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    wen = 1'b1; waddr = 4'd2; wdata = 32'hFF; sb_set = 1'b1; sb_addr = 4'd2;
    tick();
    idle_inputs();
    for (int e = 4; e <= 15; e++) tick();
    rd_addr = {4'd2, 4'd2};
    #1;
    n_checks++;
    if (ready !== 1'b1)
      $display("FAIL clrtraffic_ready: got %b want 1", ready);
    else n_pass++;
    n_checks++;
    if (rd_data[31:0] !== 32'h0 || rd_busy !== 2'b00)
      $display("FAIL clrtraffic_x2: got %h busy %b want 0 busy 00", rd_data[31:0], rd_busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_reset_mid_run();
    test_clear_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
